// File: rtl/bpu_pkg.sv
// Branch prediction unit shared definitions: BHT counter geometry, the default
// set-index width shared with the BTB, and the per-set counter container type.
package bpu_pkg;

  // Default set-index width, shared by the BHT and the BTB.
  localparam int unsigned BHT_INDEX_WIDTH = 9;

  // Two-bit saturating counters, four per set (one per fetch slot).
  localparam int unsigned BHT_CTR_W = 2;
  localparam int unsigned BHT_WAYS  = 4;

  // Weakly not-taken: the value the post-reset sweep writes.
  localparam logic [BHT_CTR_W-1:0] BHT_CTR_INIT = 2'b01;

  // Slot 0 occupies bits [1:0], slot 3 occupies bits [7:6].
  typedef logic [BHT_WAYS-1:0][BHT_CTR_W-1:0] bht_set_t;

  // Replicate one counter value across every slot of a set.
  function automatic bht_set_t bht_fill(input logic [BHT_CTR_W-1:0] ctr);
    bht_set_t s;
    for (int i = 0; i < int'(BHT_WAYS); i++) begin
      s[i] = ctr;
    end
    return s;
  endfunction

endpackage

// File: rtl/bht_table_if.sv
// Fetch read port and branch-unit update port of the branch history table.
// The master side is the fetch/branch-unit pair; the slave side is the table.
interface bht_table_if
  import bpu_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = BHT_INDEX_WIDTH
) ();

  logic                   bht_ready;
  logic                   init_done_pulse;

  // Fetch read side.
  logic                   bht_read_enable;
  logic [INDEX_WIDTH-1:0] bht_read_index;
  logic                   bht_read_valid;
  logic [7:0]             bht_read_data;

  // Branch-unit update side.
  logic                   bjusb_bht_write_enable;
  logic [INDEX_WIDTH-1:0] bjusb_bht_write_index;
  logic [1:0]             bjusb_bht_write_counter_select;
  logic                   bjusb_bht_write_inc;
  logic                   bjusb_bht_write_dec;
  logic                   bjusb_bht_valid_in;

  modport master (
    input  bht_ready,
    input  init_done_pulse,
    output bht_read_enable,
    output bht_read_index,
    input  bht_read_valid,
    input  bht_read_data,
    output bjusb_bht_write_enable,
    output bjusb_bht_write_index,
    output bjusb_bht_write_counter_select,
    output bjusb_bht_write_inc,
    output bjusb_bht_write_dec,
    output bjusb_bht_valid_in
  );

  modport slave (
    output bht_ready,
    output init_done_pulse,
    input  bht_read_enable,
    input  bht_read_index,
    output bht_read_valid,
    output bht_read_data,
    input  bjusb_bht_write_enable,
    input  bjusb_bht_write_index,
    input  bjusb_bht_write_counter_select,
    input  bjusb_bht_write_inc,
    input  bjusb_bht_write_dec,
    input  bjusb_bht_valid_in
  );

endinterface

// File: rtl/sat_ctr2.sv
// Two-bit saturating counter next-value function. Purely combinational.
// inc alone counts up to 2'b11, dec alone counts down to 2'b00, and
// inc with dec (or neither) leaves the counter unchanged.
module sat_ctr2
  import bpu_pkg::*;
(
  input  logic [BHT_CTR_W-1:0] cur_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [BHT_CTR_W-1:0] nxt_o
);

  // Saturating step selected by the exclusive inc/dec request.
  always_comb begin
    nxt_o = cur_i;
    if (inc_i && !dec_i && (cur_i != '1)) begin
      nxt_o = cur_i + 1'b1;
    end else if (dec_i && !inc_i && (cur_i != '0)) begin
      nxt_o = cur_i - 1'b1;
    end
  end

endmodule

// File: rtl/bht_table.sv
// Branch history table: 2^INDEX_WIDTH sets of four 2-bit saturating counters.
// After reset a sweep writes CTR_INIT into every set; only then are fetch
// reads and branch-unit updates accepted. Reads return registered data one
// cycle later; updates are single-cycle read-modify-writes of one counter.
//
// Build option: define BHT_WRITE_BYPASS_EN to forward an accepted update into
// a same-cycle read of the same set. Without it, such a read returns the
// pre-update contents.
module bht_table
  import bpu_pkg::*;
#(
  parameter int unsigned           INDEX_WIDTH = BHT_INDEX_WIDTH,
  parameter logic [BHT_CTR_W-1:0] CTR_INIT    = BHT_CTR_INIT
) (
  input logic        clock,
  input logic        reset_n,
  bht_table_if.slave bus
);

  localparam int unsigned NumSets = 2 ** INDEX_WIDTH;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StIdle = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic                   pulse_q, pulse_d;
  logic                   rd_valid_q, rd_valid_d;
  bht_set_t               rd_data_q, rd_data_d;

  // Counter storage; contents are established by the sweep, never by reset.
  bht_set_t               bht_mem_q [NumSets];

  logic                   ready;
  logic                   rd_acc;
  logic                   wr_acc;
  bht_set_t               wr_set;
  logic [BHT_CTR_W-1:0]   wr_cur;
  logic [BHT_CTR_W-1:0]   wr_nxt;
  bht_set_t               rd_set;

  logic                   mem_we;
  logic [INDEX_WIDTH-1:0] mem_addr;
  bht_set_t               mem_wdata;

  assign ready  = (state_q == StIdle);
  assign rd_acc = bus.bht_read_enable & ready;
  assign wr_acc = bus.bjusb_bht_write_enable & bus.bjusb_bht_valid_in & ready;

  // Current contents of the set and counter addressed by the update port.
  always_comb begin
    wr_set = bht_mem_q[bus.bjusb_bht_write_index];
    wr_cur = wr_set[bus.bjusb_bht_write_counter_select];
  end

  sat_ctr2 u_wr_ctr (
    .cur_i (wr_cur),
    .inc_i (bus.bjusb_bht_write_inc),
    .dec_i (bus.bjusb_bht_write_dec),
    .nxt_o (wr_nxt)
  );

  // Sweep owns the write port during init; afterwards it serves updates.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.bjusb_bht_write_index;
    mem_wdata = wr_set;
    mem_wdata[bus.bjusb_bht_write_counter_select] = wr_nxt;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_q;
      mem_wdata = bht_fill(CTR_INIT);
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end
  end

  // Read-side set selection, with optional forwarding of a colliding update.
  always_comb begin
    rd_set = bht_mem_q[bus.bht_read_index];
`ifdef BHT_WRITE_BYPASS_EN
    if (wr_acc && (bus.bht_read_index == bus.bjusb_bht_write_index)) begin
      rd_set[bus.bjusb_bht_write_counter_select] = wr_nxt;
    end
`endif
  end

  // Init sweep sequencing and the completion pulse.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    pulse_d = 1'b0;
    if (state_q == StInit) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) begin
        state_d = StIdle;
        pulse_d = 1'b1;
      end
    end
  end

  // Read data is held between accepted reads; valid marks each new one.
  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? rd_set : rd_data_q;
  end

  // Control and read-output state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StInit;
      sweep_q    <= '0;
      pulse_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      pulse_q    <= pulse_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Table write port; suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) begin
      bht_mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign bus.bht_ready       = ready;
  assign bus.init_done_pulse = pulse_q;
  assign bus.bht_read_valid  = rd_valid_q;
  assign bus.bht_read_data   = rd_data_q;

endmodule

// File: doc/bht_table.md
Name: bht_table

Overview:
- Branch history table that receives the branch-unit predictor update stream (bjusb_bht_*) and serves per-set counter reads to fetch.
- Holds 2^INDEX_WIDTH sets, each with 4 two-bit saturating counters, one per fetch slot.
- Sits between the branch unit (write side) and the fetch/predict stage (read side).
- After reset, a sweep FSM initialises every counter to weakly-not-taken before the table accepts traffic.

Parameters:
INDEX_WIDTH, 9, set index width; table has 2^INDEX_WIDTH sets
CTR_INIT, 2'b01, counter value written by the init sweep (weakly not-taken)

Ports:
clock  in  1  core clock
reset_n  in  1  reset; synchronous, active-low
bht_ready  out  1  high once init sweep is done; reads and writes are accepted only while high
bht_read_enable  in  1  fetch read request
bht_read_index  in  INDEX_WIDTH  set to read
bht_read_valid  out  1  read data valid, one cycle after an accepted read
bht_read_data  out  8  four counters of the set; [1:0]=slot0 … [7:6]=slot3
bjusb_bht_write_enable  in  1  update request
bjusb_bht_write_index  in  INDEX_WIDTH  set to update
bjusb_bht_write_counter_select  in  2  counter within the set
bjusb_bht_write_inc  in  1  branch taken: increment
bjusb_bht_write_dec  in  1  branch not taken: decrement
bjusb_bht_valid_in  in  1  update qualifier; update applies only when write_enable & valid_in
init_done_pulse  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (reset_n low at a clock edge) sets FSM=INIT, sweep counter=0, and drives bht_ready=0, bht_read_valid=0, bht_read_data=0, init_done_pulse=0.
- Table contents are not reset directly; the sweep initialises them.
- INIT state:
  - Each cycle writes CTR_INIT into all 4 counters of set[sweep counter], then increments the counter.
  - At counter 2^INDEX_WIDTH-1 the FSM goes to IDLE; init_done_pulse is high for exactly the first IDLE cycle.
  - Sweep lasts 2^INDEX_WIDTH cycles.
  - Reads and writes presented during INIT are dropped; there is no queuing.
  - Reset asserted mid-sweep restarts the sweep from set 0.
- IDLE state: bht_ready=1; the FSM never leaves IDLE except on reset.
- Read path:
  - An accepted read (read_enable & ready) registers the 8-bit set.
  - bht_read_valid=1 and bht_read_data are presented the next cycle.
  - Without an accepted read, bht_read_valid=0 and bht_read_data holds its last value.
- Write path:
  - An accepted update (write_enable & valid_in & ready) applies a read-modify-write to the selected counter at the clock edge; single-cycle latency.
  - inc & !dec: counter +1, saturating at 2'b11.
  - dec & !inc: counter -1, saturating at 2'b00.
  - inc & dec together, or neither: counter unchanged (no-op).
  - The other three counters of the set are untouched.
- Same-cycle read and write to the same set (see Optional Feature):
  - Default: read returns the pre-update value.
  - The write still commits.
- Back-to-back writes to the same counter on consecutive cycles: each increments/decrements relative to the value committed by the previous cycle; no lost updates.
- Index wrap: none; indices beyond range are impossible by width.

Optional Feature:
- Macro BHT_WRITE_BYPASS_EN.
- When defined: a same-cycle read and accepted write to the same set returns the post-update value in the selected slot, with other slots unchanged. Adds a comparator and a 2-bit mux per slot.
- When undefined: the read returns pre-update contents; no bypass logic is present.

Decomposition:
- Shared package (bpu_pkg): BHT_CTR_W=2, BHT_WAYS=4, BHT_CTR_INIT, and typedef bht_set_t (4x2-bit packed array).
- Shared with the BTB: default INDEX_WIDTH, shared through the same package.
- Sub-module sat_ctr2: pure combinational next-value function taking (cur, inc, dec) and producing nxt. It is instantiated per write port and in the bypass path.

Test Plan:
- Reset then idle: bht_ready=0 for 512 cycles; init_done_pulse exactly once at cycle 512; read set 0x1FF returns 8'h55.
- Reset mid-sweep at cycle 100: ready stays low a full 512 further cycles; afterwards every set reads 8'h55.
- Saturation on set 3, slot 2:
  - 3 inc updates give a read of 8'h75; a 4th inc still reads 8'h75.
  - Then 4 dec updates give a read of 8'h45.
- inc=1 and dec=1 together on set 7, slot 0 leaves the set reading 8'h55; write_enable=1 with valid_in=0 also leaves it unchanged.
- Same-cycle read+write of set 10, slot 1, inc: next-cycle data is 8'h55 without the macro, 8'h59 with BHT_WRITE_BYPASS_EN; the following read is 8'h59 in both builds.
- Back-to-back inc on set 5, slot 3 over 2 cycles reads 8'hD5; a read and a write presented during INIT produce no bht_read_valid and no table change.
